cmos_beat_packer: RTL and testbench
===================================

Name: cmos_beat_packer

Overview:
- Parametrised successor to the team's 8-to-16-bit CMOS packer.
- Packs RATIO consecutive IN_W-bit sensor beats into one IN_W*RATIO-bit word.
- Byte order selectable; trailing partial words flushed with padding; start-of-frame and end-of-line markers plus a per-line beat count.
- Sits between the CMOS capture pins (pclk domain) and the frame-buffer write path.

Parameters:
IN_W, 8, input beat width in bits
RATIO, 2, beats per output word (1..8); RATIO=1 is a pass-through with markers
MSB_FIRST, 1, 1: first beat of a word lands in the most-significant slice; 0: least-significant slice
PAD_VALUE, 0, IN_W-bit fill value for unfilled slices of a flushed partial word
LEN_W, 12, width of the line beat counter

Ports:
pclk  in  1  pixel clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
pdata_i  in  IN_W  sensor data beat
de_i  in  1  data enable (line active)
fe_i  in  1  frame enable / vsync, active high
pdata_o  out  IN_W*RATIO  packed word; zero when de_o=0
de_o  out  1  one-cycle strobe per packed word
pad_o  out  1  high with de_o when the word is a padded partial
sof_o  out  1  high with the first de_o of each frame
eol_o  out  1  one-cycle pulse marking end of line
line_len_o  out  LEN_W  input beats in the last completed line
cmos_vsync  out  1  fe_i delayed one cycle
cmos_href  out  1  de_i delayed one cycle

Behaviour:
- Reset (async, rst=1): all outputs 0; beat index, accumulator, beat counter and sof-pending flag cleared.
- Beat index idx (0..RATIO-1) advances on each cycle with de_i=1. It wraps to 0 after RATIO-1 and is forced to 0 when de_i=0.
- Slice placement:
  - MSB_FIRST=1: beat k occupies bits [IN_W*(RATIO-k)-1 : IN_W*(RATIO-1-k)].
  - MSB_FIRST=0: beat k occupies [IN_W*(k+1)-1 : IN_W*k].
  - For IN_W=8, RATIO=2, MSB_FIRST=1 the output is {first, second}.
- Full word: the cycle with de_i=1 and idx=RATIO-1 registers the word (final beat taken directly from pdata_i). pdata_o/de_o are valid on the next cycle; latency is 1 cycle after the last beat. de_o is high for exactly 1 cycle; pad_o=0.
- Partial flush: first cycle with de_i=0 while idx≠0 (de_i falling edge):
  - Register the accumulated beats; unfilled slices = PAD_VALUE.
  - de_o=1, pad_o=1 on the next cycle.
  - No flush when idx=0 at the falling edge.
- eol_o: registered (de_i delayed one cycle) & ~de_i. It pulses in the same cycle as a flushed partial word, if any.
- line_len_o:
  - Beat counter increments per de_i=1 cycle and saturates at 2^LEN_W-1.
  - Loaded into line_len_o in the cycle eol_o goes high; the counter clears at the same time.
  - line_len_o holds its value otherwise.
- sof_o:
  - fe_i rising edge (fe_i=1, previous fe_i=0) sets sof-pending.
  - The next de_o is accompanied by sof_o=1 and clears the flag.
  - A frame with no words leaves the flag set until the next word.
- fe_i rising mid-line (de_i=1, idx≠0):
  - The partial word is discarded, with no flush and no pad_o.
  - idx and the beat counter restart.
  - The beat presented on that same cycle counts as beat 0 of the new frame.
  - eol_o is not produced for the aborted line.
- Simultaneous events:
  - de_i falling and fe_i rising in the same cycle: the flush and eol_o proceed normally, and sof-pending is set.
  - sof_o is attached to the next word after that flush, not to the flushed word.
- cmos_vsync/cmos_href are plain one-cycle delays, independent of packing.
- RATIO=1: every de_i beat yields de_o the next cycle; pad_o never asserts.

Test Plan:
- Default params, fe_i rise, then a line of 4 beats 0x11,0x22,0x33,0x44 -> de_o pulses carrying 0x1122 (sof_o=1) then 0x3344. Each pulse comes 1 cycle after its second beat. eol_o follows; line_len_o=4; pad_o=0.
- MSB_FIRST=0, RATIO=4, beats 0xA0..0xA3 -> pdata_o=0xA3A2A1A0, a single de_o.
- Default params, PAD_VALUE=0xFF, line of 3 beats 0x01,0x02,0x03 -> words 0x0102, then 0x03FF with pad_o=1 and eol_o in the same cycle; line_len_o=3.
- fe_i rises after the first beat of a word (line beats 0x55 | fe↑ with 0x66, 0x77) -> 0x55 dropped, no eol_o; next word 0x6677 with sof_o=1.
- rst asserted mid-word with de_i=1 -> all outputs 0 immediately. After release, a fresh 2-beat line yields one word with idx restarted.
- LEN_W=3, line of 10 beats -> line_len_o saturates at 7.

Source files
------------

// File: rtl/cmos_beat_packer.sv
// Packs RATIO consecutive IN_W-bit CMOS beats into one wide word, with padded
// flush of trailing partial words, start-of-frame / end-of-line markers and line length.
module cmos_beat_packer #(
    parameter int              IN_W      = 8,
    parameter int              RATIO     = 2,
    parameter int              MSB_FIRST = 1,
    parameter logic [IN_W-1:0] PAD_VALUE = '0,
    parameter int              LEN_W     = 12
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       pdata_i,
    input  logic                  de_i,
    input  logic                  fe_i,
    output logic [IN_W*RATIO-1:0] pdata_o,
    output logic                  de_o,
    output logic                  pad_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic [LEN_W-1:0]      line_len_o,
    output logic                  cmos_vsync,
    output logic                  cmos_href
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Bit-slice position (in units of IN_W) occupied by beat k of a word.
    function automatic int slotOf(input int k);
        return (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
    endfunction

    logic [IDX_W-1:0] idx_q, idx_d, beatIdx;
    logic [OUT_W-1:0] acc_q, acc_d, word;
    logic [OUT_W-1:0] pdata_q, pdata_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, lineLen_q, lineLen_d;
    logic             de_q, de_d, pad_q, pad_d, sof_q, sof_d, eol_q, eol_d;
    logic             sofPend_q, sofPend_d, vsync_q, href_q;
    logic             feRise, abortLine, lastBeat, fullWord, flushWord;

    always_comb begin
        feRise    = fe_i & ~vsync_q;
        // A new frame starting mid-word throws the partial word away; this beat is beat 0.
        abortLine = feRise & de_i & (idx_q != '0);
        beatIdx   = abortLine ? '0 : idx_q;
        lastBeat  = (beatIdx == IDX_W'(RATIO - 1));
        fullWord  = de_i & lastBeat;
        flushWord = ~de_i & (idx_q != '0);

        acc_d = acc_q;
        word  = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (de_i && (k == int'(beatIdx)))
                acc_d[slotOf(k)*IN_W +: IN_W] = pdata_i;
        end
        for (int k = 0; k < RATIO; k++) begin
            if (fullWord)
                word[slotOf(k)*IN_W +: IN_W] = acc_d[slotOf(k)*IN_W +: IN_W];
            else if (k < int'(idx_q))
                word[slotOf(k)*IN_W +: IN_W] = acc_q[slotOf(k)*IN_W +: IN_W];
            else
                word[slotOf(k)*IN_W +: IN_W] = PAD_VALUE;
        end

        if (!de_i)
            idx_d = '0;
        else if (lastBeat)
            idx_d = '0;
        else
            idx_d = beatIdx + IDX_W'(1);
    end

    always_comb begin
        de_d    = fullWord | flushWord;
        pad_d   = flushWord;
        pdata_d = de_d ? word : '0;
        eol_d   = href_q & ~de_i;

        // A flushed word belongs to the old frame, so a coincident frame start waits for the next word.
        if (fullWord) begin
            sof_d     = sofPend_q | feRise;
            sofPend_d = 1'b0;
        end else if (flushWord) begin
            sof_d     = sofPend_q;
            sofPend_d = feRise;
        end else begin
            sof_d     = 1'b0;
            sofPend_d = sofPend_q | feRise;
        end

        lineLen_d = lineLen_q;
        cnt_d     = cnt_q;
        if (abortLine)
            cnt_d = LEN_W'(1);
        else if (de_i) begin
            if (cnt_q != '1)
                cnt_d = cnt_q + LEN_W'(1);
        end else if (eol_d) begin
            lineLen_d = cnt_q;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sofPend_q <= 1'b0;
            pdata_q   <= '0;
            de_q      <= 1'b0;
            pad_q     <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            lineLen_q <= '0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sofPend_q <= sofPend_d;
            pdata_q   <= pdata_d;
            de_q      <= de_d;
            pad_q     <= pad_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            lineLen_q <= lineLen_d;
            vsync_q   <= fe_i;
            href_q    <= de_i;
        end
    end

    assign pdata_o    = pdata_q;
    assign de_o       = de_q;
    assign pad_o      = pad_q;
    assign sof_o      = sof_q;
    assign eol_o      = eol_q;
    assign line_len_o = lineLen_q;
    assign cmos_vsync = vsync_q;
    assign cmos_href  = href_q;

endmodule

// File: tb/tb_cmos_beat_packer.sv
// Directed bench for cmos_beat_packer: five configurations share one stimulus stream,
// each test checks the instance whose parameters it exercises.
module tb_cmos_beat_packer;

    logic       pclk = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] pdata = '0;
    logic       de = 1'b0;
    logic       fe = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    // Instance A: default parameters
    logic [15:0] aData; logic aDe, aPad, aSof, aEol, aVs, aHr; logic [11:0] aLen;
    // Instance B: RATIO=4, LSB-first
    logic [31:0] bData; logic bDe, bPad, bSof, bEol, bVs, bHr; logic [11:0] bLen;
    // Instance C: PAD_VALUE=0xFF
    logic [15:0] cData; logic cDe, cPad, cSof, cEol, cVs, cHr; logic [11:0] cLen;
    // Instance D: LEN_W=3
    logic [15:0] dData; logic dDe, dPad, dSof, dEol, dVs, dHr; logic [2:0]  dLen;
    // Instance E: RATIO=1 pass-through
    logic [7:0]  eData; logic eDe, ePad, eSof, eEol, eVs, eHr; logic [11:0] eLen;

    cmos_beat_packer dutA (.pclk(pclk), .rst(rst), .pdata_i(pdata), .de_i(de), .fe_i(fe),
        .pdata_o(aData), .de_o(aDe), .pad_o(aPad), .sof_o(aSof), .eol_o(aEol),
        .line_len_o(aLen), .cmos_vsync(aVs), .cmos_href(aHr));

    cmos_beat_packer #(.RATIO(4), .MSB_FIRST(0)) dutB (.pclk(pclk), .rst(rst), .pdata_i(pdata),
        .de_i(de), .fe_i(fe), .pdata_o(bData), .de_o(bDe), .pad_o(bPad), .sof_o(bSof),
        .eol_o(bEol), .line_len_o(bLen), .cmos_vsync(bVs), .cmos_href(bHr));

    cmos_beat_packer #(.PAD_VALUE(8'hFF)) dutC (.pclk(pclk), .rst(rst), .pdata_i(pdata),
        .de_i(de), .fe_i(fe), .pdata_o(cData), .de_o(cDe), .pad_o(cPad), .sof_o(cSof),
        .eol_o(cEol), .line_len_o(cLen), .cmos_vsync(cVs), .cmos_href(cHr));

    cmos_beat_packer #(.LEN_W(3)) dutD (.pclk(pclk), .rst(rst), .pdata_i(pdata),
        .de_i(de), .fe_i(fe), .pdata_o(dData), .de_o(dDe), .pad_o(dPad), .sof_o(dSof),
        .eol_o(dEol), .line_len_o(dLen), .cmos_vsync(dVs), .cmos_href(dHr));

    cmos_beat_packer #(.RATIO(1)) dutE (.pclk(pclk), .rst(rst), .pdata_i(pdata),
        .de_i(de), .fe_i(fe), .pdata_o(eData), .de_o(eDe), .pad_o(ePad), .sof_o(eSof),
        .eol_o(eEol), .line_len_o(eLen), .cmos_vsync(eVs), .cmos_href(eHr));

    always #5 pclk = ~pclk;

    // Drive one cycle of inputs and land 1 ns after the capturing edge.
    task automatic applyStimulus(input logic deV, input logic feV, input logic [7:0] dataV);
        de    = deV;
        fe    = feV;
        pdata = dataV;
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #2;
        rst   = 1'b1;
        de    = 1'b1;
        fe    = 1'b1;
        pdata = 8'h5A;
        @(posedge pclk);
        #1;
        checkOutput("reset pdata", aData, 64'h0);
        checkOutput("reset de/pad/sof/eol", {aDe, aPad, aSof, aEol}, 64'h0);
        checkOutput("reset len/vsync/href", {aLen, aVs, aHr}, 64'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Line of four beats after a frame start
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("vsync delay", aVs, 64'h1);
        applyStimulus(1'b1, 1'b1, 8'h11);
        checkOutput("A no word after beat0", aDe, 64'h0);
        checkOutput("E passthrough word", {eDe, eData, eSof, ePad}, {1'b1, 8'h11, 1'b1, 1'b0});
        checkOutput("href delay", aHr, 64'h1);
        applyStimulus(1'b1, 1'b1, 8'h22);
        checkOutput("A word1", {aDe, aData, aSof, aPad}, {1'b1, 16'h1122, 1'b1, 1'b0});
        checkOutput("E second word", {eDe, eData, eSof}, {1'b1, 8'h22, 1'b0});
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkOutput("A idle between words", {aDe, aData}, 64'h0);
        applyStimulus(1'b1, 1'b1, 8'h44);
        checkOutput("A word2", {aDe, aData, aSof, aPad}, {1'b1, 16'h3344, 1'b0, 1'b0});
        checkOutput("B lsb-first 11..44", {bDe, bData}, {1'b1, 32'h44332211});
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("A eol/len/de", {aEol, aLen, aDe}, {1'b1, 12'd4, 1'b0});
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("A eol drops, len holds", {aEol, aLen}, {1'b0, 12'd4});

        // RATIO=4 LSB-first full word
        applyStimulus(1'b1, 1'b1, 8'hA0);
        applyStimulus(1'b1, 1'b1, 8'hA1);
        applyStimulus(1'b1, 1'b1, 8'hA2);
        checkOutput("B no word before 4th beat", bDe, 64'h0);
        applyStimulus(1'b1, 1'b1, 8'hA3);
        checkOutput("B word A0..A3", {bDe, bData, bPad}, {1'b1, 32'hA3A2A1A0, 1'b0});
        applyStimulus(1'b0, 1'b1, 8'h00);

        // Three-beat line: padded flush of the trailing beat
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h02);
        checkOutput("C word 0102", {cDe, cData, cPad}, {1'b1, 16'h0102, 1'b0});
        applyStimulus(1'b1, 1'b1, 8'h03);
        checkOutput("C no word mid", cDe, 64'h0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("C flush 03FF", {cDe, cData, cPad, cEol, cLen}, {1'b1, 16'h03FF, 1'b1, 1'b1, 12'd3});
        checkOutput("A flush pad zero", {aData, aPad}, {16'h0300, 1'b1});
        checkOutput("B flush 3 of 4", {bDe, bData, bPad}, {1'b1, 32'h00030201, 1'b1});
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("C flush one cycle", {cDe, cPad}, 64'h0);

        // Frame start after the first beat of a word aborts it
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b1, 8'h66);
        checkOutput("A abort no flush", {aDe, aPad, aEol}, 64'h0);
        applyStimulus(1'b1, 1'b1, 8'h77);
        checkOutput("A word after abort", {aDe, aData, aSof, aPad}, {1'b1, 16'h6677, 1'b1, 1'b0});
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("A len restarted", {aEol, aLen, aDe}, {1'b1, 12'd2, 1'b0});

        // Line end coinciding with frame start
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h81);
        applyStimulus(1'b1, 1'b0, 8'h82);
        applyStimulus(1'b1, 1'b0, 8'h83);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("A flush with fe rise", {aDe, aData, aPad, aEol, aSof}, {1'b1, 16'h8300, 1'b1, 1'b1, 1'b0});
        applyStimulus(1'b1, 1'b1, 8'h91);
        applyStimulus(1'b1, 1'b1, 8'h92);
        checkOutput("A sof on next word", {aDe, aData, aSof}, {1'b1, 16'h9192, 1'b1});
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("A len 2", aLen, 64'd2);

        // Asynchronous reset in the middle of a word
        applyStimulus(1'b1, 1'b0, 8'hC1);
        rst = 1'b1;
        #1;
        checkOutput("async reset A", {aLen, aHr, aDe}, 64'h0);
        checkOutput("async reset E", {eDe, eData}, 64'h0);
        pdata = 8'hC2;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hD1);
        checkOutput("post-reset no word", aDe, 64'h0);
        applyStimulus(1'b1, 1'b0, 8'hD2);
        checkOutput("post-reset word", {aDe, aData, aSof, aPad}, {1'b1, 16'hD1D2, 1'b0, 1'b0});
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("post-reset len", {aEol, aLen}, {1'b1, 12'd2});

        // Ten-beat line: saturation of the narrow counter
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("D len saturates", {dEol, dLen}, {1'b1, 3'd7});
        checkOutput("A len 10", aLen, 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
